// File: rtl/div_unit.sv
// Multi-cycle restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Define DIV_SIGNED_EN to build the signed path; otherwise every division is unsigned.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [64:0] dividend, dividend_n;
   logic [31:0] divisor, divisor_n;
   logic [5:0]  cnt, cnt_n;
   logic [63:0] result_n;
   logic        ready_n;

   logic [32:0] diff;
   logic [31:0] mag1, mag2;
   logic [31:0] quot, rem;

`ifdef DIV_SIGNED_EN
   logic neg1, neg1_n;
   logic neg2, neg2_n;
`else
   logic unused_sign;
   assign unused_sign = signed_div_i;
`endif

   // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_n    = state;
      dividend_n = dividend;
      divisor_n  = divisor;
      cnt_n      = cnt;
      result_n   = result_o;
      ready_n    = ready_o;
`ifdef DIV_SIGNED_EN
      neg1_n     = neg1;
      neg2_n     = neg2;
`endif

      diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
      quot = dividend[31:0];
      rem  = dividend[64:33];

`ifdef DIV_SIGNED_EN
      mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      // Flags are already qualified by signed_div_i, so DIVU never fixes up.
      if (neg1 ^ neg2) quot = -dividend[31:0];
      if (neg1)        rem  = -dividend[64:33];
`else
      mag1 = opdata1_i;
      mag2 = opdata2_i;
`endif

      case (state)
         FREE: begin
            ready_n  = 1'b0;
            result_n = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_n = BYZERO;
               end else begin
                  divisor_n  = mag2;
                  dividend_n = {32'd0, mag1, 1'b0};
                  cnt_n      = '0;
`ifdef DIV_SIGNED_EN
                  neg1_n     = signed_div_i && opdata1_i[31];
                  neg2_n     = signed_div_i && opdata2_i[31];
`endif
                  state_n    = ON;
               end
            end
         end

         BYZERO: begin
            dividend_n = '0;
            result_n   = '0;
            ready_n    = 1'b1;
            state_n    = END;
         end

         ON: begin
            if (annul_i) begin
               cnt_n   = '0;
               state_n = FREE;
            end else if (cnt != 6'd32) begin
               if (diff[32]) dividend_n = {dividend[63:0], 1'b0};
               else          dividend_n = {diff[31:0], dividend[31:0], 1'b1};
               cnt_n = cnt + 6'd1;
            end else begin
               result_n = {rem, quot};
               ready_n  = 1'b1;
               cnt_n    = '0;
               state_n  = END;
            end
         end

         END: begin
            if (!start_i) begin
               ready_n  = 1'b0;
               result_n = '0;
               cnt_n    = '0;
               state_n  = FREE;
            end
         end

         default: state_n = FREE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= FREE;
         dividend <= '0;
         divisor  <= '0;
         cnt      <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg1     <= 1'b0;
         neg2     <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         dividend <= dividend_n;
         divisor  <= divisor_n;
         cnt      <= cnt_n;
         result_o <= result_n;
         ready_o  <= ready_n;
`ifdef DIV_SIGNED_EN
         neg1     <= neg1_n;
         neg2     <= neg2_n;
`endif
      end
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider with its own sequencing FSM, serving DIV/DIVU for the EX stage. EX raises `start_i` with operands and holds it until `ready_o`; meanwhile EX requests a pipeline stall. The 64-bit result `{remainder, quotient}` is written by EX to HI/LO. The block shifts one quotient bit per cycle, handles divide-by-zero, and supports abort through `annul_i`.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  reset; synchronous, active-low
- `signed_div_i`  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by EX until it has consumed the result
- `annul_i`  in  1  abort current/pending division (flush)
- `result_o`  out  64  `{remainder[63:32], quotient[31:0]}`
- `ready_o`  out  1  result valid

## Operation
- Reset (`rst`=0 at an edge): state FREE, `cnt`=0, `dividend`=0, `divisor`=0, `result_o`=0, `ready_o`=0.
- Internal registers:
  - `dividend` 65 b
  - `divisor` 32 b
  - `cnt` 6 b
  - sign flags of both operands, latched at start
- FREE:
  - `ready_o`=0, `result_o`=0.
  - If `start_i`=1 and `annul_i`=0:
    - divisor==0 → BYZERO.
    - Otherwise latch operand magnitudes (two's-complement negate each negative operand when signed), `dividend`={32'b0, |op1|, 1'b0}, `cnt`=0 → ON.
- BYZERO: `dividend`=0 → END.
- ON:
  - If `annul_i`=1 → FREE; no result.
  - Else if `cnt`<32, one restoring step:
    - diff = {1'b0, `dividend[63:32]`} − {1'b0, divisor}.
    - diff negative: `dividend` <<= 1.
    - Otherwise: `dividend` = {diff[31:0], `dividend[31:0]`, 1'b1}.
    - `cnt`++.
  - Else (`cnt`==32) → END and latch the result:
    - quotient = `dividend[31:0]`, remainder = `dividend[64:33]`.
    - If signed: quotient negated when operand signs differ; remainder negated when the dividend was negative.
    - `result_o` = {remainder, quotient}, `ready_o`=1.
- END:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0 → FREE, clearing `ready_o` and `result_o` (`cnt`=0).
- Divide by zero: result is 64'h0. This value is architecturally defined for this core.
- Signed corner case: −2^31 / −1 gives quotient 0x80000000, remainder 0 (wraps, no trap).
- `annul_i` in FREE suppresses start. `annul_i` in END has no effect; EX drops `start_i` on flush.

## Timing
- Start sampled at edge E0.
- Nonzero divisor:
  - iterations at E1..E32
  - result registered at E33
  - `ready_o` high from E33 until the edge after `start_i` falls
- Zero divisor: BYZERO at E0, END at E1, `ready_o` high after E1.
- Annul sampled at edge Ek in ON → FREE after Ek. A new start is accepted at Ek+1 at earliest.
- `start_i` falling while in ON/BYZERO is ignored; the operation completes into END. END exits at the first edge with `start_i`=0.
- Back-to-back operations: the earliest new start is sampled one edge after END→FREE.
- `rst` low at any edge overrides every other input, including mid-operation.

## Configuration
- `DIV_SIGNED_EN` defined: signed path as above; `signed_div_i` honoured.
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` ignored and all divisions are unsigned.
  - Negate/fix-up logic and sign flags are not built.
  - Cycle timing is unchanged.

## Test plan
- Unsigned 100 / 7, start at E0: `ready_o`=0 through E32. After E33, `result_o`=64'h00000002_0000000E. Result holds while `start_i`=1. Drop `start_i` → `ready_o`=0 the next cycle.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002), `DIV_SIGNED_EN` defined → `result_o`=64'hFFFFFFFF_FFFFFFFD. Same stimulus without the macro → 64'h00000001_7FFFFFFC.
- 5 / 0 → `ready_o` after E1, `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
- 100 / 7 with `annul_i` pulsed at E10 → FREE after E10; `ready_o` never asserts. A new start 9 / 3 at E11 → after E44, `result_o`=64'h00000000_00000003.
- `rst`=0 at E15 mid-operation → all outputs 0, state FREE. A subsequent 100 / 7 completes normally.
- `start_i` and `annul_i` both high in FREE → no transition and `ready_o` stays 0.
